// File: rtl/uart_word_receiver.sv
// 8N1 UART receiver (LSB first) with 16x-style oversampling, majority voting and
// assembly of WORD_WIDTH bytes into one valid/ready output word.
module uart_word_receiver #(
  parameter int CLK_FREQUENCY = 10000000,
  parameter int BAUD_RATE     = 57600,
  parameter int OVERSAMPLE    = 16,
  parameter int WORD_WIDTH    = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      rx,
  output logic [WORD_WIDTH*8-1:0]   out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      frame_err,
  output logic                      overrun
);

  localparam int DIV = (CLK_FREQUENCY + BAUD_RATE * OVERSAMPLE / 2) / (BAUD_RATE * OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

  if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
    $error("OVERSAMPLE must be even and at least 8");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Whole FSM state in one struct so checkers can bind to a single signal.
  typedef struct packed {
    state_t        state;
    logic [SW-1:0] sub_cnt;
    logic [2:0]    bit_idx;
    logic          armed;
  } fsm_t;

  fsm_t fsm_q;
  fsm_t fsm_d;

  // Free-running baud prescaler; never realigned to the line.
  logic [DW-1:0] div_cnt;
  logic          tick;

  assign tick = (div_cnt == DW'(DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  logic [1:0] sync_q;
  logic       rxs;

  assign rxs = sync_q[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx};
    end
  end

  // sub_cnt holds the sub-tick index of the last processed tick; sub_idx is the
  // index of the tick being processed now. The vote resolves on the late sample.
  logic [SW-1:0] sub_idx;
  logic          samp_early;
  logic          samp_mid;
  logic          samp_late;
  logic          s_early;
  logic          s_mid;
  logic          vote;
  logic          data_shift;
  logic          byte_done;
  logic          stop_bad;

  assign sub_idx    = (fsm_q.sub_cnt == SW'(OVERSAMPLE - 1)) ? '0 : fsm_q.sub_cnt + SW'(1);
  assign samp_early = (sub_idx == SW'(OVERSAMPLE / 2 - 1));
  assign samp_mid   = (sub_idx == SW'(OVERSAMPLE / 2));
  assign samp_late  = (sub_idx == SW'(OVERSAMPLE / 2 + 1));
  assign vote       = (s_early & s_mid) | (s_early & rxs) | (s_mid & rxs);

  always_comb begin
    fsm_d      = fsm_q;
    data_shift = 1'b0;
    byte_done  = 1'b0;
    stop_bad   = 1'b0;
    if (tick) begin
      case (fsm_q.state)
        IDLE: begin
          if (rxs) begin
            fsm_d.armed = 1'b1;
          end else if (fsm_q.armed) begin
            fsm_d.state   = START;
            fsm_d.sub_cnt = '0;
          end
        end
        START: begin
          fsm_d.sub_cnt = sub_idx;
          if (samp_late) begin
            if (vote) begin
              fsm_d.state   = IDLE;
              fsm_d.sub_cnt = '0;
              fsm_d.armed   = 1'b1;
            end else begin
              fsm_d.state   = DATA;
              fsm_d.bit_idx = 3'd0;
            end
          end
        end
        DATA: begin
          fsm_d.sub_cnt = sub_idx;
          if (samp_late) begin
            data_shift = 1'b1;
            if (fsm_q.bit_idx == 3'd7) begin
              fsm_d.state = STOP;
            end else begin
              fsm_d.bit_idx = fsm_q.bit_idx + 3'd1;
            end
          end
        end
        STOP: begin
          fsm_d.sub_cnt = sub_idx;
          if (samp_late) begin
            fsm_d.state   = IDLE;
            fsm_d.sub_cnt = '0;
            fsm_d.bit_idx = 3'd0;
            if (vote) begin
              byte_done   = 1'b1;
              fsm_d.armed = 1'b1;
            end else begin
              // A break keeps the line low; require it to go high before re-arming.
              stop_bad    = 1'b1;
              fsm_d.armed = 1'b0;
            end
          end
        end
        default: begin
          fsm_d.state   = IDLE;
          fsm_d.sub_cnt = '0;
          fsm_d.armed   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q.state   <= IDLE;
      fsm_q.sub_cnt <= '0;
      fsm_q.bit_idx <= '0;
      fsm_q.armed   <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  logic [7:0]              shreg;
  logic [BW-1:0]           byte_cnt;
  logic [WORD_WIDTH*8-1:0] word_buf;
  logic [WORD_WIDTH*8-1:0] word_next;
  logic                    word_done;

  always_comb begin
    word_next = word_buf;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      if (byte_cnt == BW'(i)) begin
        word_next[i*8 +: 8] = shreg;
      end
    end
  end

  assign word_done = byte_done && (byte_cnt == BW'(WORD_WIDTH - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_early  <= 1'b0;
      s_mid    <= 1'b0;
      shreg    <= '0;
      byte_cnt <= '0;
      word_buf <= '0;
    end else begin
      if (tick && fsm_q.state != IDLE) begin
        if (samp_early) s_early <= rxs;
        if (samp_mid)   s_mid   <= rxs;
      end
      if (data_shift) begin
        shreg <= {vote, shreg[7:1]};
      end
      if (stop_bad) begin
        byte_cnt <= '0;
      end else if (byte_done) begin
        word_buf <= word_next;
        byte_cnt <= word_done ? '0 : byte_cnt + BW'(1);
      end
    end
  end

  // Output handshake: a word transfers on any edge where out_valid && out_ready.
  // out_data is only loaded while out_valid is low or being consumed that edge,
  // so it is stable whenever out_valid is high; a word arriving otherwise is
  // dropped and flagged with a one-clock overrun pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= word_done && out_valid && !out_ready;
      if (word_done && (!out_valid || out_ready)) begin
        out_data  <= word_next;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_word_receiver.sv
// Directed bench for uart_word_receiver: a byte-wide instance and a 2-byte-word
// instance, each fed by its own serial line at 176 clk per bit.
module tb_uart_word_receiver;

  localparam int BIT_CLK = 176;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx = 1'b1;
  logic        rx2 = 1'b1;
  logic        out_ready = 1'b1;
  logic        out_ready2 = 1'b1;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        frame_err;
  logic        overrun;
  logic [15:0] out_data2;
  logic        out_valid2;
  logic        frame_err2;
  logic        overrun2;

  int total = 0;
  int bad = 0;

  uart_word_receiver #(.WORD_WIDTH(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .rx(rx),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .frame_err(frame_err), .overrun(overrun)
  );

  uart_word_receiver #(.WORD_WIDTH(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .rx(rx2),
    .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2),
    .frame_err(frame_err2), .overrun(overrun2)
  );

  // clock / cycle counter
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // output monitors (event counters sampled on the falling edge)
  int          n_rise = 0, n_vcyc = 0, n_fe = 0, n_ov = 0, rise_cyc = 0;
  logic [7:0]  rise_data = '0;
  logic        prev_valid = 1'b0;
  int          n_rise2 = 0, n_fe2 = 0, n_ov2 = 0;
  logic [15:0] rise_data2 = '0;
  logic        prev_valid2 = 1'b0;

  always @(negedge clk) begin
    prev_valid <= out_valid;
    if (out_valid && !prev_valid) begin
      n_rise    <= n_rise + 1;
      rise_cyc  <= cyc;
      rise_data <= out_data;
    end
    if (out_valid) n_vcyc <= n_vcyc + 1;
    if (frame_err) n_fe <= n_fe + 1;
    if (overrun)   n_ov <= n_ov + 1;
    prev_valid2 <= out_valid2;
    if (out_valid2 && !prev_valid2) begin
      n_rise2    <= n_rise2 + 1;
      rise_data2 <= out_data2;
    end
    if (frame_err2) n_fe2 <= n_fe2 + 1;
    if (overrun2)   n_ov2 <= n_ov2 + 1;
  end

  // driver tasks
  int stop_cyc = 0;

  task automatic drive(input bit lane2, input logic v, input int nclk);
    if (lane2) rx2 = v;
    else       rx  = v;
    repeat (nclk) @(posedge clk);
  endtask

  task automatic send_frame(input bit lane2, input logic [7:0] b, input logic stop);
    logic [7:0] d;
    d = b;
    drive(lane2, 1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) drive(lane2, d[i], BIT_CLK);
    stop_cyc = cyc;
    drive(lane2, stop, BIT_CLK);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // scenarios
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (5) @(posedge clk);
    settle();
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", frame_err, overrun); end
    total++; if (out_data2 !== 16'h0000 || out_valid2 !== 1'b0) begin bad++; $display("FAIL reset_dut2 got=%h/%b exp=0000/0", out_data2, out_valid2); end
    reset_n = 1'b1;
    repeat (2 * BIT_CLK) @(posedge clk);
  endtask

  task automatic test_single();
    int r0, v0, f0, o0, lat;
    settle();
    r0 = n_rise; v0 = n_vcyc; f0 = n_fe; o0 = n_ov;
    send_frame(1'b0, 8'hA5, 1'b1);
    repeat (20) @(posedge clk);
    settle();
    lat = rise_cyc - stop_cyc;
    total++; if (n_rise - r0 !== 1) begin bad++; $display("FAIL a5_words got=%0d exp=1", n_rise - r0); end
    total++; if (rise_data !== 8'hA5) begin bad++; $display("FAIL a5_data got=%h exp=a5", rise_data); end
    total++; if (n_vcyc - v0 !== 1) begin bad++; $display("FAIL a5_valid_width got=%0d exp=1", n_vcyc - v0); end
    total++; if (lat < 95 || lat > 120) begin bad++; $display("FAIL a5_latency got=%0d exp=95..120 clk into stop bit", lat); end
    total++; if (n_fe - f0 !== 0 || n_ov - o0 !== 0) begin bad++; $display("FAIL a5_flags got=fe%0d ov%0d exp=0 0", n_fe - f0, n_ov - o0); end
  endtask

  task automatic test_glitch();
    int r0, f0;
    settle();
    r0 = n_rise; f0 = n_fe;
    drive(1'b0, 1'b0, 40);
    drive(1'b0, 1'b1, 2 * BIT_CLK);
    settle();
    total++; if (n_rise - r0 !== 0) begin bad++; $display("FAIL glitch_words got=%0d exp=0", n_rise - r0); end
    total++; if (n_fe - f0 !== 0) begin bad++; $display("FAIL glitch_fe got=%0d exp=0", n_fe - f0); end
    send_frame(1'b0, 8'h3C, 1'b1);
    repeat (20) @(posedge clk);
    settle();
    total++; if (n_rise - r0 !== 1 || rise_data !== 8'h3C) begin bad++; $display("FAIL glitch_next got=%0d/%h exp=1/3c", n_rise - r0, rise_data); end
  endtask

  task automatic test_break();
    int r0, f0;
    settle();
    r0 = n_rise; f0 = n_fe;
    send_frame(1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 20 * BIT_CLK);
    settle();
    total++; if (n_fe - f0 !== 1) begin bad++; $display("FAIL break_fe got=%0d exp=1", n_fe - f0); end
    total++; if (n_rise - r0 !== 0) begin bad++; $display("FAIL break_words got=%0d exp=0", n_rise - r0); end
    drive(1'b0, 1'b1, BIT_CLK);
    send_frame(1'b0, 8'h81, 1'b1);
    repeat (20) @(posedge clk);
    settle();
    total++; if (n_rise - r0 !== 1 || rise_data !== 8'h81) begin bad++; $display("FAIL break_next got=%0d/%h exp=1/81", n_rise - r0, rise_data); end
    total++; if (n_fe - f0 !== 1) begin bad++; $display("FAIL break_fe_total got=%0d exp=1", n_fe - f0); end
  endtask

  task automatic test_overrun();
    int r0, o0;
    settle();
    r0 = n_rise; o0 = n_ov;
    out_ready = 1'b0;
    send_frame(1'b0, 8'h11, 1'b1);
    send_frame(1'b0, 8'h22, 1'b1);
    repeat (20) @(posedge clk);
    settle();
    total++; if (out_data !== 8'h11 || out_valid !== 1'b1) begin bad++; $display("FAIL ovr_hold got=%h/%b exp=11/1", out_data, out_valid); end
    total++; if (n_ov - o0 !== 1) begin bad++; $display("FAIL ovr_pulses got=%0d exp=1", n_ov - o0); end
    total++; if (n_rise - r0 !== 1) begin bad++; $display("FAIL ovr_words got=%0d exp=1", n_rise - r0); end
    out_ready = 1'b1;
    settle();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ovr_release got=%b exp=0", out_valid); end
    total++; if (out_data !== 8'h11) begin bad++; $display("FAIL ovr_data_kept got=%h exp=11", out_data); end
    repeat (BIT_CLK) @(posedge clk);
  endtask

  task automatic test_word2();
    int r0, f0;
    settle();
    r0 = n_rise2; f0 = n_fe2;
    send_frame(1'b1, 8'h34, 1'b1);
    send_frame(1'b1, 8'h12, 1'b1);
    repeat (20) @(posedge clk);
    settle();
    total++; if (n_rise2 - r0 !== 1 || rise_data2 !== 16'h1234) begin bad++; $display("FAIL w2_first got=%0d/%h exp=1/1234", n_rise2 - r0, rise_data2); end
    send_frame(1'b1, 8'h34, 1'b1);
    send_frame(1'b1, 8'hFF, 1'b0);
    drive(1'b1, 1'b1, BIT_CLK);
    settle();
    total++; if (n_fe2 - f0 !== 1) begin bad++; $display("FAIL w2_fe got=%0d exp=1", n_fe2 - f0); end
    send_frame(1'b1, 8'h78, 1'b1);
    send_frame(1'b1, 8'h56, 1'b1);
    repeat (20) @(posedge clk);
    settle();
    total++; if (n_rise2 - r0 !== 2 || rise_data2 !== 16'h5678) begin bad++; $display("FAIL w2_second got=%0d/%h exp=2/5678", n_rise2 - r0, rise_data2); end
    total++; if (n_ov2 !== 0) begin bad++; $display("FAIL w2_overrun got=%0d exp=0", n_ov2); end
  endtask

  task automatic test_reset_mid();
    int r0, f0;
    drive(1'b0, 1'b0, BIT_CLK + 300);
    reset_n = 1'b0;
    repeat (5) @(posedge clk);
    settle();
    total++; if (out_data !== 8'h00 || out_valid !== 1'b0) begin bad++; $display("FAIL rmid_reset got=%h/%b exp=00/0", out_data, out_valid); end
    r0 = n_rise; f0 = n_fe;
    reset_n = 1'b1;
    drive(1'b0, 1'b0, 3 * BIT_CLK);
    settle();
    total++; if (n_rise - r0 !== 0 || n_fe - f0 !== 0) begin bad++; $display("FAIL rmid_nostart got=%0d/%0d exp=0/0", n_rise - r0, n_fe - f0); end
    drive(1'b0, 1'b1, BIT_CLK);
    send_frame(1'b0, 8'h5A, 1'b1);
    repeat (20) @(posedge clk);
    settle();
    total++; if (n_rise - r0 !== 1 || rise_data !== 8'h5A) begin bad++; $display("FAIL rmid_next got=%0d/%h exp=1/5a", n_rise - r0, rise_data); end
    total++; if (n_fe - f0 !== 0) begin bad++; $display("FAIL rmid_fe got=%0d exp=0", n_fe - f0); end
  endtask

  // sequence and final report
  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_break();
    test_overrun();
    test_word2();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
